// File: rtl/dw_gray_pkg.sv
// dw_gray_pkg: shared pointer-width constants and Gray/binary conversion helpers
// Gray/binary helpers work on 32-bit operands; callers zero-extend narrower pointers and truncate the result.
package dw_gray_pkg;
    localparam int def_addr_width = 4;
    localparam int ptr_w = def_addr_width + 1;
    localparam int depth = 1 << def_addr_width;

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction
endpackage

// File: rtl/dw_gray_sync.sv
// dw_gray_sync: sync_stages-deep register chain for a Gray pointer crossing into clk
// Ports: clk, rst_n (sync, active-low), d (async Gray input), q (last stage).
module dw_gray_sync #(
    parameter int width = 5,
    parameter int sync_stages = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);
    logic [sync_stages-1:0][width-1:0] r_chain;

    always_ff @(posedge clk)
        if (!rst_n) r_chain <= '0;
        else        r_chain <= {r_chain[sync_stages-2:0], d};

    assign q = r_chain[sync_stages-1];
endmodule

// File: rtl/dw_gray_rd_ptr_ctl.sv
// dw_gray_rd_ptr_ctl: read-side pointer controller of a Gray-pointer FIFO
// Ports: clk, rst_n (sync, active-low); wr_ptr_gray (async Gray write pointer); rd_en (pop request);
// pop, rd_addr, rd_ptr_gray (to writer); empty, almost_empty, word_count; sticky underflow, ptr_err.
module dw_gray_rd_ptr_ctl
    import dw_gray_pkg::*;
#(
    parameter int addr_width = def_addr_width,
    parameter int sync_stages = 2,
    parameter int ae_level = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [addr_width:0] wr_ptr_gray,
    input  logic                rd_en,
    output logic                pop,
    output logic [addr_width-1:0] rd_addr,
    output logic [addr_width:0] rd_ptr_gray,
    output logic                empty,
    output logic                almost_empty,
    output logic [addr_width:0] word_count,
    output logic                underflow,
    output logic                ptr_err
);
    localparam int pw = addr_width + 1;
    localparam logic [pw-1:0] lp_depth = pw'(1 << addr_width);
    localparam logic [pw-1:0] lp_ae = pw'(ae_level);

    logic [pw-1:0] w_wr_gray_s, w_wr_bin_s, w_rd_bin_nxt, w_cnt_nxt;
    logic [pw-1:0] r_rd_bin, r_rd_gray, r_word_count;
    logic          r_empty, r_almost_empty, r_underflow, r_ptr_err;

    dw_gray_sync #(.width(pw), .sync_stages(sync_stages)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (wr_ptr_gray),
        .q    (w_wr_gray_s)
    );

    assign w_wr_bin_s   = pw'(gray2bin(32'(w_wr_gray_s)));
    assign pop          = rd_en & ~r_empty;
    assign w_rd_bin_nxt = r_rd_bin + pw'(pop);
    // Count is taken from next-state pointers so a pop is reflected in the flags on the very next edge.
    assign w_cnt_nxt    = w_wr_bin_s - w_rd_bin_nxt;

    always_ff @(posedge clk)
        if (!rst_n) begin
            r_rd_bin       <= '0;
            r_rd_gray      <= '0;
            r_word_count   <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_underflow    <= 1'b0;
            r_ptr_err      <= 1'b0;
        end else begin
            r_rd_bin       <= w_rd_bin_nxt;
            r_rd_gray      <= pw'(bin2gray(32'(w_rd_bin_nxt)));
            r_word_count   <= w_cnt_nxt;
            r_empty        <= w_cnt_nxt == '0;
            r_almost_empty <= w_cnt_nxt <= lp_ae;
            r_underflow    <= r_underflow | (rd_en & r_empty);
            r_ptr_err      <= r_ptr_err | (w_cnt_nxt > lp_depth);
        end

    assign rd_addr      = r_rd_bin[addr_width-1:0];
    assign rd_ptr_gray  = r_rd_gray;
    assign word_count   = r_word_count;
    assign empty        = r_empty;
    assign almost_empty = r_almost_empty;
    assign underflow    = r_underflow;
    assign ptr_err      = r_ptr_err;
endmodule

// File: tb/tb_dw_gray_rd_ptr_ctl.sv
// tb_dw_gray_rd_ptr_ctl: directed self-checking bench for dw_gray_rd_ptr_ctl (addr_width=4, sync_stages=2, ae_level=1)
module tb_dw_gray_rd_ptr_ctl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] wr_ptr_gray = '0;
    logic       rd_en = 1'b0;
    logic       pop, empty, almost_empty, underflow, ptr_err;
    logic [3:0] rd_addr;
    logic [4:0] rd_ptr_gray, word_count;
    int total = 0;
    int bad = 0;

    dw_gray_rd_ptr_ctl #(.addr_width(4), .sync_stages(2), .ae_level(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_ptr_gray (wr_ptr_gray),
        .rd_en       (rd_en),
        .pop         (pop),
        .rd_addr     (rd_addr),
        .rd_ptr_gray (rd_ptr_gray),
        .empty       (empty),
        .almost_empty(almost_empty),
        .word_count  (word_count),
        .underflow   (underflow),
        .ptr_err     (ptr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] gray(input int b);
        logic [4:0] x;
        x = 5'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pop_n(input int n);
        rd_en = 1'b1;
        step(n);
        rd_en = 1'b0;
    endtask

    initial begin
        // reset with a nonzero write pointer present
        wr_ptr_gray = 5'b01010;
        step(3);
        chk("rst_empty", empty, 1);
        chk("rst_ae", almost_empty, 1);
        chk("rst_wc", word_count, 0);
        chk("rst_rdg", rd_ptr_gray, 0);
        chk("rst_uf", underflow, 0);
        chk("rst_perr", ptr_err, 0);
        rst_n = 1'b1;
        step(2);
        chk("rel_still_empty", empty, 1);
        step(1);
        chk("rel_empty_fall", empty, 0);
        chk("rel_wc12", word_count, 12);
        // clean restart with writer also reset
        rst_n = 1'b0;
        wr_ptr_gray = '0;
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("clean_empty", empty, 1);
        // single-entry latency
        wr_ptr_gray = gray(1);
        step(2);
        chk("lat_empty_2", empty, 1);
        step(1);
        chk("lat_empty_3", empty, 0);
        chk("lat_wc", word_count, 1);
        chk("lat_ae", almost_empty, 1);
        rd_en = 1'b1;
        #1;
        chk("single_pop", pop, 1);
        chk("single_addr", rd_addr, 0);
        step(1);
        rd_en = 1'b0;
        chk("single_empty", empty, 1);
        chk("single_rdg", rd_ptr_gray, 5'b00001);
        chk("single_wc", word_count, 0);
        // fill (rd_bin=1): wr bin 2 -> count 1, bin 3 -> count 2
        wr_ptr_gray = gray(2);
        step(3);
        chk("fill_wc1", word_count, 1);
        chk("fill_ae1", almost_empty, 1);
        wr_ptr_gray = gray(3);
        step(3);
        chk("fill_wc2", word_count, 2);
        chk("fill_ae2", almost_empty, 0);
        for (int b = 4; b <= 17; b++) begin
            wr_ptr_gray = gray(b);
            step(1);
        end
        step(2);
        chk("full_wc", word_count, 16);
        chk("full_empty", empty, 0);
        chk("full_perr", ptr_err, 0);
        // drain 16 entries, rd_addr 1..15,0
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("drain_pop", pop, 1);
            chk("drain_addr", rd_addr, (1 + i) % 16);
            step(1);
        end
        rd_en = 1'b0;
        chk("drain_empty", empty, 1);
        chk("drain_wc", word_count, 0);
        chk("drain_rdg", rd_ptr_gray, 5'b11001);
        // underflow
        rd_en = 1'b1;
        #1;
        chk("uf_pop", pop, 0);
        step(2);
        rd_en = 1'b0;
        chk("uf_set", underflow, 1);
        chk("uf_addr_hold", rd_addr, 1);
        chk("uf_rdg_hold", rd_ptr_gray, 5'b11001);
        step(1);
        chk("uf_sticky", underflow, 1);
        // wrap: bring rd_bin to 31 with write bin 0 (count 1)
        rst_n = 1'b0;
        wr_ptr_gray = '0;
        step(2);
        chk("uf_cleared", underflow, 0);
        rst_n = 1'b1;
        wr_ptr_gray = gray(16);
        step(3);
        pop_n(16);
        wr_ptr_gray = gray(31);
        step(3);
        chk("wrap_wc15", word_count, 15);
        pop_n(15);
        wr_ptr_gray = gray(0);
        step(3);
        chk("wrap_wc1", word_count, 1);
        chk("wrap_rdg31", rd_ptr_gray, 5'b10000);
        chk("wrap_addr15", rd_addr, 15);
        rd_en = 1'b1;
        #1;
        chk("wrap_pop", pop, 1);
        step(1);
        rd_en = 1'b0;
        chk("wrap_rdg0", rd_ptr_gray, 0);
        chk("wrap_addr0", rd_addr, 0);
        chk("wrap_empty", empty, 1);
        chk("wrap_perr", ptr_err, 0);
        // corrupt pointer: jump straight to bin 20
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        wr_ptr_gray = gray(20);
        step(2);
        chk("perr_early", ptr_err, 0);
        step(1);
        chk("perr_set", ptr_err, 1);
        chk("perr_wc", word_count, 20);
        chk("perr_ae", almost_empty, 0);
        // pop coincides with synchronized write advance
        wr_ptr_gray = gray(21);
        step(2);
        chk("simul_pre_wc", word_count, 20);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        chk("simul_wc", word_count, 20);
        chk("simul_addr", rd_addr, 1);
        chk("perr_sticky", ptr_err, 1);
        rst_n = 1'b0;
        step(1);
        chk("perr_cleared", ptr_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
